// File: rtl/ram_dp_arbiter.sv
// Purpose: round-robin arbiter that shares the A/B ports of a true dual-port RAM between NR_REQ requesters.
// Latency: grants and RAM drive are combinational; read data returns one cycle after the grant.
// Backpressure: req_ready marks the winners; losers and hazard-blocked requests stay pending at the requester.
//
// Ports: clock/reset_ (async, active-low); req_valid/req_ready/req_wr/req_addr/req_wdata request side
// (packed per requester); rsp_valid/rsp_rdata read return; init_done; ram_{address,wren,data,q}_{a,b} RAM side.
// Build option: define RAM_ARB_INIT_EN to clear the RAM to zero after reset before any grant.
module ram_dp_arbiter #(
  parameter int NR_REQ = 4,
  parameter int DEPTH  = 512,
  parameter int WIDTH  = 8,
  localparam int DEPTH_BITS = $clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ-1:0]            req_wr,
  input  logic [NR_REQ*DEPTH_BITS-1:0] req_addr,
  input  logic [NR_REQ*WIDTH-1:0]      req_wdata,
  output logic [NR_REQ-1:0]            rsp_valid,
  output logic [NR_REQ*WIDTH-1:0]      rsp_rdata,
  output logic                         init_done,
  output logic [DEPTH_BITS-1:0]        ram_address_a,
  output logic                         ram_wren_a,
  output logic [WIDTH-1:0]             ram_data_a,
  input  logic [WIDTH-1:0]             ram_q_a,
  output logic [DEPTH_BITS-1:0]        ram_address_b,
  output logic                         ram_wren_b,
  output logic [WIDTH-1:0]             ram_data_b,
  input  logic [WIDTH-1:0]             ram_q_b
);

  localparam int IDXW = $clog2(NR_REQ);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    init_done_q, init_done_d;
  logic [DEPTH_BITS-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [WIDTH-1:0]        data_a_q, data_a_d, data_b_q, data_b_d;
  logic [NR_REQ-1:0]       rd_vld_q, rd_vld_d, rd_port_q, rd_port_d;
  logic [NR_REQ*WIDTH-1:0] rdata_q, rdata_d;

`ifdef RAM_ARB_INIT_EN
  localparam logic [DEPTH_BITS:0] CNT_ONE = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS:0] CNT_TWO = (DEPTH_BITS+1)'(2);
  localparam logic [DEPTH_BITS:0] DEPTH_C = (DEPTH_BITS+1)'(DEPTH);
  // One spare bit so cnt+2 cannot wrap on the final clear step.
  logic [DEPTH_BITS:0]     cnt_q, cnt_d, cnt_p1;
`endif

  logic                    a_vld, b_vld, b_gnt;
  logic [IDXW-1:0]         a_idx, b_idx;
  logic [DEPTH_BITS-1:0]   a_addr, b_addr;
  int                      srch_idx;

  function automatic logic [IDXW-1:0] nxt(input logic [IDXW-1:0] i);
    return (i == IDXW'(NR_REQ-1)) ? '0 : i + 1'b1;
  endfunction

  // Circular search from rr_ptr: first valid requester takes port A, the next one port B.
  always_comb begin
    a_vld    = 1'b0;
    b_vld    = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    srch_idx = 0;
    for (int k = 0; k < NR_REQ; k++) begin
      srch_idx = int'(rr_ptr_q) + k;
      if (srch_idx >= NR_REQ) srch_idx = srch_idx - NR_REQ;
      if (req_valid[IDXW'(srch_idx)]) begin
        if (!a_vld) begin
          a_vld = 1'b1;
          a_idx = IDXW'(srch_idx);
        end else if (!b_vld) begin
          b_vld = 1'b1;
          b_idx = IDXW'(srch_idx);
        end
      end
    end
  end

  assign a_addr = req_addr[a_idx*DEPTH_BITS +: DEPTH_BITS];
  assign b_addr = req_addr[b_idx*DEPTH_BITS +: DEPTH_BITS];
  // Same address on both ports is only safe when both are reads.
  assign b_gnt  = b_vld && !((a_addr == b_addr) && (req_wr[a_idx] || req_wr[b_idx]));

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    init_done_d = init_done_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    rd_vld_d    = '0;
    rd_port_d   = rd_port_q;
    req_ready   = '0;
    ram_wren_a  = 1'b0;
    ram_wren_b  = 1'b0;
`ifdef RAM_ARB_INIT_EN
    cnt_d       = cnt_q;
    cnt_p1      = cnt_q + CNT_ONE;
`endif
    case (state_q)
      ST_INIT: begin
`ifdef RAM_ARB_INIT_EN
        // Gate with reset_ so the clear writes never reach the RAM while reset is held.
        if (reset_) begin
          ram_wren_a = 1'b1;
          addr_a_d   = cnt_q[DEPTH_BITS-1:0];
          data_a_d   = '0;
          if (cnt_p1 < DEPTH_C) begin
            ram_wren_b = 1'b1;
            addr_b_d   = cnt_p1[DEPTH_BITS-1:0];
            data_b_d   = '0;
          end
          cnt_d = cnt_q + CNT_TWO;
          if (cnt_q + CNT_TWO >= DEPTH_C) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
          end
        end
`else
        state_d     = ST_RUN;
        init_done_d = 1'b1;
`endif
      end
      default: begin
        if (a_vld) begin
          req_ready[a_idx] = 1'b1;
          ram_wren_a       = req_wr[a_idx];
          addr_a_d         = a_addr;
          data_a_d         = req_wdata[a_idx*WIDTH +: WIDTH];
          if (!req_wr[a_idx]) begin
            rd_vld_d[a_idx]  = 1'b1;
            rd_port_d[a_idx] = 1'b0;
          end
          rr_ptr_d = nxt(a_idx);
        end
        if (b_gnt) begin
          req_ready[b_idx] = 1'b1;
          ram_wren_b       = req_wr[b_idx];
          addr_b_d         = b_addr;
          data_b_d         = req_wdata[b_idx*WIDTH +: WIDTH];
          if (!req_wr[b_idx]) begin
            rd_vld_d[b_idx]  = 1'b1;
            rd_port_d[b_idx] = 1'b1;
          end
          rr_ptr_d = nxt(b_idx);
        end
      end
    endcase
  end

  // Read data: show the RAM output in the return cycle, then keep showing it.
  always_comb begin
    rdata_d = rdata_q;
    for (int i = 0; i < NR_REQ; i++) begin
      if (rd_vld_q[i]) rdata_d[i*WIDTH +: WIDTH] = rd_port_q[i] ? ram_q_b : ram_q_a;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q     <= ST_INIT;
      rr_ptr_q    <= '0;
      init_done_q <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      rd_vld_q    <= '0;
      rd_port_q   <= '0;
      rdata_q     <= '0;
`ifdef RAM_ARB_INIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      init_done_q <= init_done_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      rd_vld_q    <= rd_vld_d;
      rd_port_q   <= rd_port_d;
      rdata_q     <= rdata_d;
`ifdef RAM_ARB_INIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign ram_address_a = addr_a_d;
  assign ram_data_a    = data_a_d;
  assign ram_address_b = addr_b_d;
  assign ram_data_b    = data_b_d;
  assign rsp_valid     = rd_vld_q;
  assign rsp_rdata     = rdata_d;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Bench for ram_dp_arbiter: a dual-port RAM model on the RAM side, a queue-based
// reference of the arbitration/return rules checked every cycle, and directed
// scenarios with literal expectations.
module tb_ram_dp_arbiter;
  localparam int NR    = 4;
  localparam int DEPTH = 64;
  localparam int W     = 8;
  localparam int DB    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR-1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [NR*DB-1:0] req_addr;
  logic [NR*W-1:0]  req_wdata, rsp_rdata;
  logic             init_done;
  logic [DB-1:0]    ram_address_a, ram_address_b;
  logic             ram_wren_a, ram_wren_b;
  logic [W-1:0]     ram_data_a, ram_data_b, ram_q_a, ram_q_b;

  int n_cmp = 0;
  int n_err = 0;

  ram_dp_arbiter #(.NR_REQ(NR), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .clock(clk), .reset_(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .ram_address_a(ram_address_a), .ram_wren_a(ram_wren_a), .ram_data_a(ram_data_a), .ram_q_a(ram_q_a),
    .ram_address_b(ram_address_b), .ram_wren_b(ram_wren_b), .ram_data_b(ram_data_b), .ram_q_b(ram_q_b)
  );

  // True dual-port RAM, registered read, old data on read-during-write.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wren_a) ram[ram_address_a] <= ram_data_a;
    if (ram_wren_b) ram[ram_address_b] <= ram_data_b;
    ram_q_a <= ram[ram_address_a];
    ram_q_b <= ram[ram_address_b];
  end

  function automatic logic [W-1:0] pat(input int a);
    return W'(a) ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int raddr(input int i);
    return int'(req_addr[i*DB +: DB]);
  endfunction

  function automatic logic [W-1:0] rdat(input int i);
    return req_wdata[i*W +: W];
  endfunction

  // ---------------- reference model, checked every cycle ----------------
  logic [W-1:0] m_mem  [DEPTH];
  logic [W-1:0] m_exp  [NR];
  logic [W-1:0] m_hold [NR];
  bit           m_run;
  int           m_cnt, m_rr;
  bit [NR-1:0]  m_pend;

  always @(negedge clk) begin
    bit [NR-1:0]  e_rdy;
    bit           ua, ub, e_wa, e_wb;
    int           ea, eb, ga, gb;
    logic [W-1:0] eda, edb, er;
    int           order[$];
    if (!rst_n) begin
      chk("m_rst_ready", 32'(req_ready), 0);
      chk("m_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("m_rst_rdata", rsp_rdata, 0);
      chk("m_rst_init_done", 32'(init_done), 0);
      chk("m_rst_wren", {30'd0, ram_wren_a, ram_wren_b}, 0);
      chk("m_rst_addr", {20'd0, ram_address_a, ram_address_b}, 0);
      chk("m_rst_data", {16'd0, ram_data_a, ram_data_b}, 0);
      m_run = 0; m_cnt = 0; m_rr = 0; m_pend = '0;
      for (int i = 0; i < NR; i++) m_hold[i] = '0;
    end else begin
      e_rdy = '0; ua = 0; ub = 0; e_wa = 0; e_wb = 0;
      ea = 0; eb = 0; eda = '0; edb = '0; ga = -1; gb = -1;
      if (!m_run) begin
`ifdef RAM_ARB_INIT_EN
        ua = 1; e_wa = 1; ea = m_cnt;
        if (m_cnt + 1 < DEPTH) begin ub = 1; e_wb = 1; eb = m_cnt + 1; end
`endif
      end else begin
        order.delete();
        for (int k = 0; k < NR; k++)
          if (req_valid[(m_rr + k) % NR]) order.push_back((m_rr + k) % NR);
        if (order.size() > 0) ga = order[0];
        if (order.size() > 1) begin
          gb = order[1];
          if (raddr(ga) == raddr(gb) && (req_wr[ga] || req_wr[gb])) gb = -1;
        end
        if (ga >= 0) begin e_rdy[ga] = 1; ua = 1; e_wa = req_wr[ga]; ea = raddr(ga); eda = rdat(ga); end
        if (gb >= 0) begin e_rdy[gb] = 1; ub = 1; e_wb = req_wr[gb]; eb = raddr(gb); edb = rdat(gb); end
      end
      chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
      chk("m_wren_a", 32'(ram_wren_a), 32'(e_wa));
      chk("m_wren_b", 32'(ram_wren_b), 32'(e_wb));
      if (ua) chk("m_addr_a", 32'(ram_address_a), ea);
      if (ub) chk("m_addr_b", 32'(ram_address_b), eb);
      if (e_wa) chk("m_data_a", 32'(ram_data_a), 32'(eda));
      if (e_wb) chk("m_data_b", 32'(ram_data_b), 32'(edb));
      chk("m_rsp_valid", 32'(rsp_valid), 32'(m_pend));
      for (int i = 0; i < NR; i++) begin
        er = m_pend[i] ? m_exp[i] : m_hold[i];
        chk("m_rsp_rdata", 32'(rsp_rdata[i*W +: W]), 32'(er));
        m_hold[i] = er;
      end
      chk("m_init_done", 32'(init_done), 32'(m_run));
      m_pend = '0;
      if (ga >= 0 && !req_wr[ga]) begin m_pend[ga] = 1; m_exp[ga] = m_mem[ea]; end
      if (gb >= 0 && !req_wr[gb]) begin m_pend[gb] = 1; m_exp[gb] = m_mem[eb]; end
      if (e_wa) m_mem[ea] = eda;
      if (e_wb) m_mem[eb] = edb;
      if (gb >= 0) m_rr = (gb + 1) % NR;
      else if (ga >= 0) m_rr = (ga + 1) % NR;
      if (!m_run) begin
`ifdef RAM_ARB_INIT_EN
        m_cnt += 2;
        if (m_cnt >= DEPTH) m_run = 1;
`else
        m_run = 1;
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clr();
    req_valid = '0;
    req_wr    = '0;
  endtask

  task automatic rq(input int i, input bit wr, input int a, input int d);
    req_valid[i]        = 1'b1;
    req_wr[i]           = wr;
    req_addr[i*DB +: DB] = DB'(a);
    req_wdata[i*W +: W]  = W'(d);
  endtask

  task automatic wait_init(input string name);
    for (int c = 0; c < 200; c++) begin
      if (init_done) break;
      smp();
    end
    chk(name, 32'(init_done), 1);
  endtask

  initial begin
    int nwr;
    rst_n = 1'b0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    for (int a = 0; a < DEPTH; a++) begin
      ram[a]   <= pat(a);
      m_mem[a] = pat(a);
    end
    repeat (3) @(posedge clk);
    smp();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_wren", {30'd0, ram_wren_a, ram_wren_b}, 0);

    // Clear sequence
    step(); rst_n = 1'b1;
    nwr = 0;
    for (int c = 0; c < 200; c++) begin
      smp();
      if (init_done) break;
`ifdef RAM_ARB_INIT_EN
      if (c == 0) chk("clear_first_pair", {26'd0, ram_address_a, ram_address_b}, 32'({6'd0, 6'd1}));
      if (c == 1) chk("clear_second_pair", {26'd0, ram_address_a, ram_address_b}, 32'({6'd2, 6'd3}));
`endif
      if (ram_wren_a && ram_wren_b) nwr++;
    end
    chk("init_done_up", 32'(init_done), 1);
`ifdef RAM_ARB_INIT_EN
    chk("clear_cycles", nwr, DEPTH / 2);
`else
    chk("clear_cycles", nwr, 0);
`endif

    // Read of address 5 after clear
    step(); clr(); rq(2, 0, 5, 0); smp();
    chk("rd5_ready", 32'(req_ready), 32'(4'b0100));
    step(); clr(); smp();
    chk("rd5_vld", 32'(rsp_valid), 32'(4'b0100));
`ifdef RAM_ARB_INIT_EN
    chk("rd5_data", 32'(rsp_rdata[2*W +: W]), 0);
`else
    chk("rd5_data", 32'(rsp_rdata[2*W +: W]), 32'(pat(5)));
`endif

    // Dual grant writes, then reads
    step(); clr(); rq(0, 1, 'h10, 'hAB); rq(1, 1, 'h11, 'hCD); smp();
    chk("dual_wr_ready", 32'(req_ready), 32'(4'b0011));
    chk("dual_wr_wren", {30'd0, ram_wren_a, ram_wren_b}, 3);
    step(); clr(); rq(0, 0, 'h10, 0); rq(1, 0, 'h11, 0); smp();
    chk("dual_rd_ready", 32'(req_ready), 32'(4'b0011));
    chk("wr_no_rsp", 32'(rsp_valid), 0);
    step(); clr(); smp();
    chk("dual_rsp_vld", 32'(rsp_valid), 32'(4'b0011));
    chk("dual_rsp_d0", 32'(rsp_rdata[0 +: W]), 32'h0AB);
    chk("dual_rsp_d1", 32'(rsp_rdata[W +: W]), 32'h0CD);
    step(); clr(); smp();
    chk("rsp_pulse", 32'(rsp_valid), 0);
    chk("rsp_hold", 32'(rsp_rdata[0 +: W]), 32'h0AB);

    // Hazard: bring rr_ptr to 0 by granting requester 3 alone
    step(); clr(); rq(3, 0, 'h30, 0); smp();
    chk("rr_to0_ready", 32'(req_ready), 32'(4'b1000));
    step(); clr(); rq(0, 1, 'h20, 'h77); rq(1, 0, 'h20, 0); smp();
    chk("haz_ready", 32'(req_ready), 32'(4'b0001));
    chk("haz_b_idle", 32'(ram_wren_b), 0);
    step(); clr(); rq(1, 0, 'h20, 0); smp();
    chk("haz_retry_ready", 32'(req_ready), 32'(4'b0010));
    step(); clr(); smp();
    chk("haz_rsp_vld", 32'(rsp_valid), 32'(4'b0010));
    chk("haz_rsp_data", 32'(rsp_rdata[W +: W]), 32'h077);

    // Fairness with all four reading continuously
    step(); clr(); rq(3, 0, 'h31, 0); smp();
    chk("rr_to0b_ready", 32'(req_ready), 32'(4'b1000));
    for (int c = 0; c < 6; c++) begin
      step(); clr();
      for (int i = 0; i < NR; i++) rq(i, 0, 'h10 + i, 0);
      smp();
      chk("fair_ready", 32'(req_ready), (c % 2 == 0) ? 32'(4'b0011) : 32'(4'b1100));
    end

    // Two reads of the same address in one cycle
    step(); clr(); rq(0, 0, 'h10, 0); rq(1, 0, 'h10, 0); smp();
    chk("same_rd_ready", 32'(req_ready), 32'(4'b0011));
    step(); clr(); smp();
    chk("same_rd_d0", 32'(rsp_rdata[0 +: W]), 32'h0AB);
    chk("same_rd_d1", 32'(rsp_rdata[W +: W]), 32'h0AB);

    // Wrap: rr_ptr to 3, then valid on 3 and 0
    step(); clr(); rq(2, 0, 'h12, 0); smp();
    chk("rr_to3_ready", 32'(req_ready), 32'(4'b0100));
    step(); clr(); rq(3, 0, 'h13, 0); rq(0, 0, 'h10, 0); smp();
    chk("wrap_ready", 32'(req_ready), 32'(4'b1001));
    chk("wrap_ports", {20'd0, ram_address_a, ram_address_b}, 32'({6'h13, 6'h10}));
    step(); clr();
    for (int i = 0; i < NR; i++) rq(i, 0, 'h10 + i, 0);
    smp();
    chk("wrap_rr1_ready", 32'(req_ready), 32'(4'b0110));

    // Reset in the cycle after a read grant
    step(); clr(); rq(0, 0, 'h11, 0); smp();
    chk("pre_rst_ready", 32'(req_ready), 32'(4'b0001));
    step(); clr(); rst_n = 1'b0; smp();
    chk("midrst_rsp_vld", 32'(rsp_valid), 0);
    chk("midrst_rdata", rsp_rdata, 0);
    chk("midrst_init_done", 32'(init_done), 0);
    step(); rst_n = 1'b1; smp();
`ifdef RAM_ARB_INIT_EN
    chk("reinit_first", {25'd0, ram_wren_a, ram_address_a, ram_address_b}, 32'({1'b1, 6'd0, 6'd1}));
`endif
    wait_init("reinit_done");
    step(); clr(); rq(1, 0, 'h11, 0); smp();
    step(); clr(); smp();
    chk("post_rst_vld", 32'(rsp_valid), 32'(4'b0010));
`ifdef RAM_ARB_INIT_EN
    chk("post_rst_data", 32'(rsp_rdata[W +: W]), 0);
`else
    chk("post_rst_data", 32'(rsp_rdata[W +: W]), 32'h0CD);
`endif
    step(); clr(); smp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
